// File: rtl/fetch_ctrl_if.sv
// Fetch-side signal bundle: instruction-memory request/done handshake plus the decode interface.
// master = fetch_ctrl, slave = memory/decode environment.
interface fetch_ctrl_if;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        stall_in;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        trap;
  logic        rti;
  logic [15:0] trap_epc;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic [15:0] instr_pc2;
  logic        halted;
  logic [15:0] epc;

  modport master (
    output imem_addr, imem_rd, instr, instr_valid, instr_pc, instr_pc2, halted, epc,
    input  imem_done, imem_data, stall_in, redirect, redirect_pc, halt, trap, rti, trap_epc
  );

  modport slave (
    input  imem_addr, imem_rd, instr, instr_valid, instr_pc, instr_pc2, halted, epc,
    output imem_done, imem_data, stall_in, redirect, redirect_pc, halt, trap, rti, trap_epc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, request/done memory handshake, one-entry decode buffer.
// Optional trap entry/return is enabled by defining FETCH_TRAP_EN.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] TRAP_VEC = 16'h0002
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StRun, StWait, StDrain, StHalted} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] tgt_q, tgt_d;
  logic        tgt_pend_q, tgt_pend_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic [15:0] instr_pc2_q, instr_pc2_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halt_pend_q, halt_pend_d;

  logic        redir;
  logic [15:0] redir_pc;
  logic        halt_pend;
  logic        can_issue;
  logic        rd;
  logic        capture;
  logic        active;
  logic        in_flight;
  logic [15:0] pc_inc;

  assign pc_inc    = pc_q + 16'd2;
  assign halt_pend = halt_pend_q | bus.halt;
  assign can_issue = !instr_valid_q || !bus.stall_in;
  assign active    = (state_q != StHalted);
  assign in_flight = (state_q == StWait) || (state_q == StDrain);

`ifdef FETCH_TRAP_EN
  logic [15:0] epc_q, epc_d;

  always_comb begin
    redir = bus.trap | bus.rti | bus.redirect;
    if (bus.trap) begin
      redir_pc = TRAP_VEC;
    end else if (bus.rti) begin
      redir_pc = epc_q;
    end else begin
      redir_pc = bus.redirect_pc;
    end
    epc_d = epc_q;
    if (active && bus.trap) begin
      epc_d = bus.trap_epc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q <= 16'h0000;
    end else begin
      epc_q <= epc_d;
    end
  end

  assign bus.epc = epc_q;
`else
  logic unused_trap;
  assign unused_trap = ^{bus.trap, bus.rti, bus.trap_epc, TRAP_VEC};
  assign redir       = bus.redirect;
  assign redir_pc    = bus.redirect_pc;
  assign bus.epc     = 16'h0000;
`endif

  // Sequencing: decides the request strobe and whether this cycle's completion is kept.
  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    capture = 1'b0;
    case (state_q)
      StRun: begin
        rd = can_issue && !redir && !halt_pend;
        if (halt_pend) begin
          state_d = StHalted;
        end else if (rd) begin
          if (bus.imem_done) begin
            capture = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        rd = 1'b1;
        if (bus.imem_done) begin
          state_d = halt_pend ? StHalted : StRun;
          capture = !redir && !halt_pend;
        end else if (redir || halt_pend) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        rd = 1'b1;
        if (bus.imem_done) begin
          state_d = halt_pend ? StHalted : StRun;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    tgt_pend_d    = tgt_pend_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_pc2_d   = instr_pc2_q;
    instr_valid_d = instr_valid_q;
    halt_pend_d   = halt_pend_q | bus.halt;

    if (capture) begin
      instr_d       = bus.imem_data;
      instr_pc_d    = pc_q;
      instr_pc2_d   = pc_inc;
      instr_valid_d = 1'b1;
      pc_d          = pc_inc;
    end else if (instr_valid_q && !bus.stall_in) begin
      instr_valid_d = 1'b0;
    end

    // imem_addr must stay on the outstanding request, so a redirect that lands
    // mid-request is parked in tgt_q and applied when the request completes.
    if (active && redir) begin
      instr_valid_d = 1'b0;
      if (in_flight && !bus.imem_done) begin
        tgt_d      = redir_pc;
        tgt_pend_d = 1'b1;
      end else begin
        pc_d       = redir_pc;
        tgt_pend_d = 1'b0;
      end
    end else if (in_flight && bus.imem_done && tgt_pend_q) begin
      pc_d       = tgt_q;
      tgt_pend_d = 1'b0;
    end

    if (halt_pend || (state_d == StHalted)) begin
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      tgt_q         <= RESET_PC;
      tgt_pend_q    <= 1'b0;
      instr_q       <= 16'h0800;
      instr_pc_q    <= 16'h0000;
      instr_pc2_q   <= 16'h0000;
      instr_valid_q <= 1'b0;
      halt_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      tgt_q         <= tgt_d;
      tgt_pend_q    <= tgt_pend_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_pc2_q   <= instr_pc2_d;
      instr_valid_q <= instr_valid_d;
      halt_pend_q   <= halt_pend_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.imem_rd     = rd && !rst;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_pc2   = instr_pc2_q;
  assign bus.halted      = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: vector table from reset, directed multi-cycle corners, then random
// stimulus against a transaction-level reference model.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] TRAP_VEC = 16'h0002;

  logic clk = 1'b0;
  logic rst;
  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int mem_lat = 0;
  int wait_cnt;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory: done arrives once the request has been held for mem_lat cycles.
  assign bus.imem_done = bus.imem_rd && (wait_cnt >= mem_lat);
  assign bus.imem_data = mem_word(bus.imem_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (bus.imem_rd && bus.imem_done) wait_cnt <= 0;
    else if (bus.imem_rd) wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic clear_in();
    bus.stall_in = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 16'h0000;
    bus.halt = 1'b0; bus.trap = 1'b0; bus.rti = 1'b0; bus.trap_epc = 16'h0000;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_ipc;
    logic [15:0] exp_pc2;
  } vec_t;
  vec_t vt[12];

  // Reference model: one outstanding request (busy/squash/req), buffer, next PC.
  logic [15:0] m_pc, m_req, m_instr, m_ipc, m_pc2, m_epc;
  logic        m_busy, m_squash, m_valid, m_hp, m_halted;

  task automatic model_reset();
    m_pc = RESET_PC; m_req = RESET_PC; m_instr = 16'h0800; m_ipc = 16'h0000; m_pc2 = 16'h0000;
    m_epc = 16'h0000; m_busy = 0; m_squash = 0; m_valid = 0; m_hp = 0; m_halted = 0;
  endtask

  task automatic model_redir(output logic r, output logic [15:0] t);
    r = bus.redirect;
    t = bus.redirect_pc;
`ifdef FETCH_TRAP_EN
    if (bus.trap) begin r = 1; t = TRAP_VEC; end
    else if (bus.rti) begin r = 1; t = m_epc; end
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " rd"}, bus.imem_rd, 1'b0);
    chk({tag, " addr"}, bus.imem_addr, RESET_PC);
    chk({tag, " valid"}, bus.instr_valid, 1'b0);
    chk({tag, " instr"}, bus.instr, 16'h0800);
    chk({tag, " ipc"}, bus.instr_pc, 16'h0000);
    chk({tag, " pc2"}, bus.instr_pc2, 16'h0000);
    chk({tag, " halted"}, bus.halted, 1'b0);
    chk({tag, " epc"}, bus.epc, 16'h0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_redir, e_rd, hp, keep, r_stall;
    logic [15:0] r_tgt, cur;
    int          n;

    clear_in();
    rst = 1'b1;
    #3;
    check_reset_outputs("reset");
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // ---- vector table: single-cycle memory, back-pressure, wrap-around redirect
    vt[0]  = '{0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000};
    vt[1]  = '{0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000, 16'h0002};
    vt[2]  = '{0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0002, 16'h0004};
    vt[3]  = '{1, 0, 16'h0000, 0, 16'h0006, 1, 16'h0004, 16'h0006};
    vt[4]  = '{1, 0, 16'h0000, 0, 16'h0006, 1, 16'h0004, 16'h0006};
    vt[5]  = '{1, 0, 16'h0000, 0, 16'h0006, 1, 16'h0004, 16'h0006};
    vt[6]  = '{0, 0, 16'h0000, 1, 16'h0006, 1, 16'h0004, 16'h0006};
    vt[7]  = '{0, 0, 16'h0000, 1, 16'h0008, 1, 16'h0006, 16'h0008};
    vt[8]  = '{0, 1, 16'hFFFE, 0, 16'h000A, 1, 16'h0008, 16'h000A};
    vt[9]  = '{0, 0, 16'h0000, 1, 16'hFFFE, 0, 16'h0008, 16'h000A};
    vt[10] = '{0, 0, 16'h0000, 1, 16'h0000, 1, 16'hFFFE, 16'h0000};
    vt[11] = '{0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000, 16'h0002};
    do_reset();
    mem_lat = 0;
    for (int i = 0; i < 12; i++) begin
      bus.stall_in = vt[i].stall; bus.redirect = vt[i].redir; bus.redirect_pc = vt[i].rpc;
      #2;
      chk($sformatf("vec%0d rd", i), bus.imem_rd, vt[i].exp_rd);
      chk($sformatf("vec%0d addr", i), bus.imem_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d valid", i), bus.instr_valid, vt[i].exp_valid);
      chk($sformatf("vec%0d ipc", i), bus.instr_pc, vt[i].exp_ipc);
      chk($sformatf("vec%0d pc2", i), bus.instr_pc2, vt[i].exp_pc2);
      if (vt[i].exp_valid) chk($sformatf("vec%0d instr", i), bus.instr, mem_word(vt[i].exp_ipc));
      next_cycle();
    end
    clear_in();

    // ---- redirect one cycle into a slow fetch of 0x0002
    do_reset();
    mem_lat = 3;
    repeat (4) next_cycle();
    #2;
    chk("slow c4 addr", bus.imem_addr, 16'h0002);
    chk("slow c4 ipc", bus.instr_pc, 16'h0000);
    next_cycle();
    bus.redirect = 1; bus.redirect_pc = 16'h0100;
    #2;
    chk("slow redir rd", bus.imem_rd, 1'b1);
    chk("slow redir addr", bus.imem_addr, 16'h0002);
    next_cycle();
    bus.redirect = 0;
    for (int c = 6; c < 8; c++) begin
      #2;
      chk($sformatf("slow drain%0d rd", c), bus.imem_rd, 1'b1);
      chk($sformatf("slow drain%0d addr", c), bus.imem_addr, 16'h0002);
      chk($sformatf("slow drain%0d valid", c), bus.instr_valid, 1'b0);
      next_cycle();
    end
    #2;
    chk("slow refetch rd", bus.imem_rd, 1'b1);
    chk("slow refetch addr", bus.imem_addr, 16'h0100);
    n = 0;
    while (!bus.instr_valid && n < 10) begin
      chk("slow no stale data", bus.instr_valid, 1'b0);
      next_cycle();
      #2;
      n++;
    end
    chk("slow valid", bus.instr_valid, 1'b1);
    chk("slow ipc", bus.instr_pc, 16'h0100);
    chk("slow instr", bus.instr, mem_word(16'h0100));

    // ---- halt during WAIT
    next_cycle();
    do_reset();
    mem_lat = 3;
    next_cycle();
    bus.halt = 1;
    #2;
    chk("halt wait rd", bus.imem_rd, 1'b1);
    next_cycle();
    bus.halt = 0;
    for (int c = 2; c < 4; c++) begin
      #2;
      chk($sformatf("halt drain%0d rd", c), bus.imem_rd, 1'b1);
      chk($sformatf("halt drain%0d halted", c), bus.halted, 1'b0);
      next_cycle();
    end
    for (int c = 0; c < 6; c++) begin
      bus.redirect = (c == 2); bus.redirect_pc = 16'h0200;
      #2;
      chk($sformatf("halted%0d halted", c), bus.halted, 1'b1);
      chk($sformatf("halted%0d rd", c), bus.imem_rd, 1'b0);
      chk($sformatf("halted%0d valid", c), bus.instr_valid, 1'b0);
      chk($sformatf("halted%0d addr", c), bus.imem_addr, 16'h0000);
      next_cycle();
    end
    clear_in();

    // ---- reset pulse in the middle of WAIT on 0x0002
    do_reset();
    mem_lat = 3;
    repeat (5) next_cycle();
    #1;
    chk("rstwait pre rd", bus.imem_rd, 1'b1);
    chk("rstwait pre pc2", bus.instr_pc2, 16'h0002);
    rst = 1'b1;
    #1;
    check_reset_outputs("rstwait");
    next_cycle();
    rst = 1'b0;
    #2;
    chk("rstwait refetch rd", bus.imem_rd, 1'b1);
    chk("rstwait refetch addr", bus.imem_addr, RESET_PC);
    next_cycle();

    // ---- trap / return
    do_reset();
    mem_lat = 0;
    next_cycle();
    bus.trap = 1; bus.trap_epc = 16'h0040;
    #2;
`ifdef FETCH_TRAP_EN
    chk("trap rd", bus.imem_rd, 1'b0);
    next_cycle();
    bus.trap = 0;
    #2;
    chk("trap addr", bus.imem_addr, TRAP_VEC);
    chk("trap epc", bus.epc, 16'h0040);
    next_cycle();
    bus.rti = 1;
    #2;
    chk("rti rd", bus.imem_rd, 1'b0);
    next_cycle();
    bus.rti = 0;
    #2;
    chk("rti addr", bus.imem_addr, 16'h0040);
    chk("rti rd2", bus.imem_rd, 1'b1);
`else
    chk("notrap rd", bus.imem_rd, 1'b1);
    chk("notrap addr", bus.imem_addr, 16'h0002);
    next_cycle();
    bus.trap = 0; bus.rti = 1;
    #2;
    chk("notrap addr2", bus.imem_addr, 16'h0004);
    chk("notrap epc", bus.epc, 16'h0000);
    next_cycle();
    bus.rti = 0;
    #2;
    chk("notrap addr3", bus.imem_addr, 16'h0006);
`endif
    next_cycle();

    // ---- random stimulus against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 7) == 0)) begin
        clear_in();
        rst = 1'b1;
        #2;
        check_reset_outputs("rand reset");
        model_reset();
        next_cycle();
        rst = 1'b0;
        continue;
      end
      mem_lat = $urandom_range(0, 3);
      bus.stall_in = ($urandom_range(0, 9) < 3);
      bus.redirect = ($urandom_range(0, 11) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom_range(0, 32767) << 1);
      bus.halt = ($urandom_range(0, 399) == 0);
      bus.trap = ($urandom_range(0, 39) == 0);
      bus.rti = ($urandom_range(0, 39) == 0);
      bus.trap_epc = 16'($urandom_range(0, 32767) << 1);
      #2;
      model_redir(r_redir, r_tgt);
      hp = m_hp || bus.halt;
      r_stall = bus.stall_in;
      if (m_halted) e_rd = 0;
      else if (m_busy) e_rd = 1;
      else e_rd = (!m_valid || !r_stall) && !r_redir && !hp;
      cur = m_busy ? m_req : m_pc;
      chk("rand rd", bus.imem_rd, e_rd);
      chk("rand addr", bus.imem_addr, cur);
      chk("rand valid", bus.instr_valid, m_valid);
      chk("rand instr", bus.instr, m_instr);
      chk("rand ipc", bus.instr_pc, m_ipc);
      chk("rand pc2", bus.instr_pc2, m_pc2);
      chk("rand halted", bus.halted, m_halted);
      chk("rand epc", bus.epc, m_epc);
      if (!m_halted) begin
        keep = e_rd && bus.imem_done && !m_squash && !r_redir && !hp;
        if (keep) begin
          m_valid = 1; m_instr = mem_word(cur); m_ipc = cur; m_pc2 = cur + 16'd2;
          m_pc = cur + 16'd2;
        end else if (m_valid && !r_stall) begin
          m_valid = 0;
        end
        if (e_rd && !bus.imem_done) begin
          m_req = cur;
          m_busy = 1;
          if (r_redir || hp) m_squash = 1;
        end else if (e_rd) begin
          m_busy = 0;
          m_squash = 0;
        end
        if (r_redir) begin
          m_pc = r_tgt;
          m_valid = 0;
`ifdef FETCH_TRAP_EN
          if (bus.trap) m_epc = bus.trap_epc;
`endif
        end
        if (hp) begin
          m_hp = 1;
          m_valid = 0;
        end
        m_halted = m_hp && !m_busy;
      end
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
